// File: rtl/i3_router_rr_wrarb_pkg.sv
// Shared definitions for the packet-locked round-robin FIFO write arbiter:
// mux select codes, flit class codes and the arbiter state enumeration.
package i3_router_rr_wrarb_pkg;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_P1   = 2'b01;
  localparam logic [1:0] SEL_P2   = 2'b10;
  localparam logic [1:0] SEL_P3   = 2'b11;

  localparam logic [2:0] HEAD_REGULAR  = 3'b000;
  localparam logic [2:0] HEAD_PRIORITY = 3'b001;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } wrarb_state_e;

  // Port select code to one-hot port vector, bit 0 = port1.
  function automatic logic [2:0] sel_onehot(input logic [1:0] sel);
    case (sel)
      SEL_P1:  return 3'b001;
      SEL_P2:  return 3'b010;
      SEL_P3:  return 3'b011 & 3'b100 | 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/i3_router_rr_wrarb_rr_pick3.sv
// rr_pick3: combinational three-way round-robin picker. The winner is the first
// eligible port after rr_ptr in the cyclic order 1 -> 2 -> 3 -> 1.
module rr_pick3
  import i3_router_rr_wrarb_pkg::*;
(
  input  logic [2:0] elig,
  input  logic [1:0] rr_ptr,
  output logic [1:0] winner,
  output logic       valid
);

  // Search order rotates so the last-granted port is considered last.
  always_comb begin
    winner = SEL_NONE;
    valid  = |elig;
    case (rr_ptr)
      SEL_P1: begin
        if (elig[1])      winner = SEL_P2;
        else if (elig[2]) winner = SEL_P3;
        else if (elig[0]) winner = SEL_P1;
        else              winner = SEL_NONE;
      end
      SEL_P2: begin
        if (elig[2])      winner = SEL_P3;
        else if (elig[0]) winner = SEL_P1;
        else if (elig[1]) winner = SEL_P2;
        else              winner = SEL_NONE;
      end
      default: begin
        if (elig[0])      winner = SEL_P1;
        else if (elig[1]) winner = SEL_P2;
        else if (elig[2]) winner = SEL_P3;
        else              winner = SEL_NONE;
      end
    endcase
  end

endmodule

// File: rtl/i3_router_rr_wrarb.sv
// Packet-locked round-robin write arbiter for one router FIFO shared by three
// input ports. Optional stall timeout/abort is enabled by WRARB_TIMEOUT_EN.
module i3_router_rr_wrarb
  import i3_router_rr_wrarb_pkg::*;
#(
  parameter logic [2:0] HEAD    = HEAD_REGULAR,
  parameter int         PKT_LEN = 4,
  parameter int         CNT_W   = 3
`ifdef WRARB_TIMEOUT_EN
  , parameter int       TIMEOUT = 16
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       input_req1,
  input  logic       input_req2,
  input  logic       input_req3,
  input  logic [2:0] head1,
  input  logic [2:0] head2,
  input  logic [2:0] head3,
  input  logic       FIFO_full,
  output logic       input_bussy1,
  output logic       input_bussy2,
  output logic       input_bussy3,
  output logic       FIFO_wr,
  output logic [1:0] select
`ifdef WRARB_TIMEOUT_EN
  , output logic     pkt_abort
`endif
);

  wrarb_state_e     state_r, state_nx_s;
  logic [1:0]       lock_port_r, rr_ptr_r;
  logic [CNT_W-1:0] remain_r;

  logic [2:0] req_s, elig_s, lock_oh_s, win_oh_s, busy_s;
  logic [1:0] winner_s, sel_s;
  logic       valid_s, lock_req_s, wr_s;

`ifdef WRARB_TIMEOUT_EN
  localparam int ST_W = $clog2(TIMEOUT + 1);
  logic [ST_W-1:0] stall_r;
  logic            abort_s;
`endif

  assign req_s      = {input_req3, input_req2, input_req1};
  assign elig_s     = req_s & {head3 == HEAD, head2 == HEAD, head1 == HEAD};
  assign lock_oh_s  = sel_onehot(lock_port_r);
  assign win_oh_s   = sel_onehot(winner_s);
  assign lock_req_s = |(req_s & lock_oh_s);

  rr_pick3 u_pick (
    .elig   (elig_s),
    .rr_ptr (rr_ptr_r),
    .winner (winner_s),
    .valid  (valid_s)
  );

  // Zero-latency grant/mux outputs and next state; reset forces the idle outputs.
  always_comb begin
    wr_s       = 1'b0;
    sel_s      = SEL_NONE;
    busy_s     = 3'b111;
    state_nx_s = state_r;
`ifdef WRARB_TIMEOUT_EN
    abort_s    = 1'b0;
`endif
    if (!reset) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (valid_s && !FIFO_full) begin
            sel_s      = winner_s;
            wr_s       = 1'b1;
            busy_s     = ~win_oh_s;
            state_nx_s = (PKT_LEN == 1) ? ST_IDLE : ST_LOCK;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_LOCK: begin
          sel_s  = lock_port_r;
          busy_s = ~lock_oh_s | ({3{FIFO_full}} & lock_oh_s);
          wr_s   = lock_req_s & !FIFO_full;
          if (wr_s && (remain_r == CNT_W'(1))) begin
            state_nx_s = ST_IDLE;
`ifdef WRARB_TIMEOUT_EN
          end else if (!lock_req_s && (stall_r == ST_W'(TIMEOUT - 1))) begin
            abort_s    = 1'b1;
            state_nx_s = ST_IDLE;
`endif
          end else begin
            state_nx_s = ST_LOCK;
          end
        end
        default: state_nx_s = ST_IDLE;
      endcase
    end
  end

  // Arbitration state: lock owner, flits remaining, last-granted pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      lock_port_r <= SEL_NONE;
      remain_r    <= '0;
      rr_ptr_r    <= SEL_P3;
`ifdef WRARB_TIMEOUT_EN
      stall_r     <= '0;
`endif
    end else begin
      state_r <= state_nx_s;
      case (state_r)
        ST_IDLE: begin
          if (wr_s) begin
            if (PKT_LEN == 1) begin
              rr_ptr_r <= winner_s;
            end else begin
              lock_port_r <= winner_s;
              remain_r    <= CNT_W'(PKT_LEN - 1);
            end
`ifdef WRARB_TIMEOUT_EN
            stall_r <= '0;
`endif
          end
        end
        ST_LOCK: begin
          if (wr_s) begin
            remain_r <= remain_r - CNT_W'(1);
            if (remain_r == CNT_W'(1)) begin
              rr_ptr_r <= lock_port_r;
            end
`ifdef WRARB_TIMEOUT_EN
            stall_r <= '0;
          end else if (abort_s) begin
            rr_ptr_r <= lock_port_r;
            remain_r <= '0;
            stall_r  <= '0;
          end else if (!lock_req_s) begin
            stall_r <= stall_r + ST_W'(1);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign FIFO_wr      = wr_s;
  assign select       = sel_s;
  assign input_bussy1 = busy_s[0];
  assign input_bussy2 = busy_s[1];
  assign input_bussy3 = busy_s[2];
`ifdef WRARB_TIMEOUT_EN
  assign pkt_abort    = abort_s;
`endif

endmodule

// File: tb/tb_i3_router_rr_wrarb.sv
// Self-checking bench for i3_router_rr_wrarb: a regular-class and a priority-class
// instance share the input stimulus and are compared against a packet-level model.
`timescale 1ns/1ps
module tb_i3_router_rr_wrarb;
  import i3_router_rr_wrarb_pkg::*;

  localparam int PKT_LEN = 4;
  localparam int TIMEOUT = 16;
`ifdef WRARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] req = 3'b000;
  logic [2:0] hd1 = 3'b000, hd2 = 3'b000, hd3 = 3'b000;
  logic       full = 1'b0;
  logic [2:0] busy_r, busy_p;
  logic       wr_r, wr_p, ab_r, ab_p;
  logic [1:0] sel_r, sel_p;

  int checks = 0;
  int errors = 0;

  // Model: per instance, locked port (0 = none), flits left, last granted, stall count.
  int m_port [2];
  int m_left [2];
  int m_last [2];
  int m_stall[2];
  logic [6:0] exp_v[2];
  logic [6:0] obs_v[2];

  always #5 clk = ~clk;

  i3_router_rr_wrarb #(.HEAD(HEAD_REGULAR), .PKT_LEN(PKT_LEN), .CNT_W(3)) dut_r (
    .clk(clk), .reset(reset),
    .input_req1(req[0]), .input_req2(req[1]), .input_req3(req[2]),
    .head1(hd1), .head2(hd2), .head3(hd3), .FIFO_full(full),
    .input_bussy1(busy_r[0]), .input_bussy2(busy_r[1]), .input_bussy3(busy_r[2]),
    .FIFO_wr(wr_r), .select(sel_r)
`ifdef WRARB_TIMEOUT_EN
    , .pkt_abort(ab_r)
`endif
  );

  i3_router_rr_wrarb #(.HEAD(HEAD_PRIORITY), .PKT_LEN(PKT_LEN), .CNT_W(3)) dut_p (
    .clk(clk), .reset(reset),
    .input_req1(req[0]), .input_req2(req[1]), .input_req3(req[2]),
    .head1(hd1), .head2(hd2), .head3(hd3), .FIFO_full(full),
    .input_bussy1(busy_p[0]), .input_bussy2(busy_p[1]), .input_bussy3(busy_p[2]),
    .FIFO_wr(wr_p), .select(sel_p)
`ifdef WRARB_TIMEOUT_EN
    , .pkt_abort(ab_p)
`endif
  );

`ifndef WRARB_TIMEOUT_EN
  assign ab_r = 1'b0;
  assign ab_p = 1'b0;
`endif

  function automatic logic [2:0] head_of(input int p);
    if (p == 1) return hd1;
    else if (p == 2) return hd2;
    else return hd3;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_port[k] = 0; m_left[k] = 0; m_last[k] = 3; m_stall[k] = 0;
    end
  endtask

  // Expected {abort, wr, select, busy3..1} for this cycle; advances the model past the edge.
  task automatic predict(input int k, output logic [6:0] e);
    logic       ewr, eab;
    logic [1:0] esel;
    logic [2:0] ebusy, cls;
    int w, p;
    ewr = 1'b0; eab = 1'b0; esel = 2'b00; ebusy = 3'b111;
    cls = (k == 0) ? 3'b000 : 3'b001;
    if (!reset) begin
      m_port[k] = 0; m_left[k] = 0; m_last[k] = 3; m_stall[k] = 0;
    end else if (m_port[k] == 0) begin
      w = 0;
      for (int s = 1; s <= 3; s++) begin
        p = (m_last[k] + s - 1) % 3 + 1;
        if (w == 0 && req[p-1] && head_of(p) == cls) w = p;
      end
      if (w != 0 && !full) begin
        ewr = 1'b1; esel = 2'(w); ebusy[w-1] = 1'b0; m_stall[k] = 0;
        if (PKT_LEN == 1) m_last[k] = w;
        else begin m_port[k] = w; m_left[k] = PKT_LEN - 1; end
      end
    end else begin
      p = m_port[k];
      esel = 2'(p);
      ebusy[p-1] = full;
      if (req[p-1] && !full) begin
        ewr = 1'b1; m_left[k]--; m_stall[k] = 0;
        if (m_left[k] == 0) begin m_last[k] = p; m_port[k] = 0; end
      end else if (!req[p-1] && TO_EN) begin
        m_stall[k]++;
        if (m_stall[k] == TIMEOUT) begin
          eab = 1'b1; m_last[k] = p; m_port[k] = 0; m_stall[k] = 0;
        end
      end
    end
    e = {eab, ewr, esel, ebusy};
  endtask

  task automatic sample();
    @(negedge clk);
    for (int k = 0; k < 2; k++) predict(k, exp_v[k]);
    obs_v[0] = {ab_r, wr_r, sel_r, busy_r};
    obs_v[1] = {ab_p, wr_p, sel_p, busy_p};
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0; req = 3'b000; full = 1'b0;
    @(posedge clk); #1;
    model_reset();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    req = 3'b111; hd1 = 3'b000; hd2 = 3'b000; hd3 = 3'b001; reset = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 2; c++) begin
      sample();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_v[k] !== exp_v[k]) begin
          errors++;
          $display("FAIL reset cyc=%0d dut%0d got %b want %b", c, k, obs_v[k], exp_v[k]);
        end
      end
    end
    model_reset();
    req = 3'b000; reset = 1'b1;
  endtask

  task automatic test_single_packet();
    int nwr;
    nwr = 0;
    apply_reset();
    req = 3'b010; hd2 = 3'b000;
    for (int c = 0; c < 6; c++) begin
      if (c == 4) req = 3'b000;
      sample();
      if (obs_v[0][5]) nwr++;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_v[k] !== exp_v[k]) begin
          errors++;
          $display("FAIL single_pkt cyc=%0d dut%0d got %b want %b", c, k, obs_v[k], exp_v[k]);
        end
      end
    end
    checks++;
    if (nwr !== 4) begin
      errors++;
      $display("FAIL single_pkt_writes got %0d want 4", nwr);
    end
  endtask

  task automatic test_fairness();
    int nwr;
    int order[3];
    nwr = 0;
    apply_reset();
    req = 3'b111; hd1 = 3'b000; hd2 = 3'b000; hd3 = 3'b000;
    for (int c = 0; c < 12; c++) begin
      sample();
      if (obs_v[0][5]) begin
        if (nwr % PKT_LEN == 0 && nwr / PKT_LEN < 3) order[nwr / PKT_LEN] = int'(obs_v[0][4:3]);
        nwr++;
      end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_v[k] !== exp_v[k]) begin
          errors++;
          $display("FAIL fairness cyc=%0d dut%0d got %b want %b", c, k, obs_v[k], exp_v[k]);
        end
      end
    end
    req = 3'b000;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (nwr < (i + 1) * PKT_LEN || order[i] !== i + 1) begin
        errors++;
        $display("FAIL fairness_order pkt=%0d got port %0d want port %0d", i, order[i], i + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    int nwr;
    nwr = 0;
    apply_reset();
    req = 3'b001; hd1 = 3'b000;
    for (int c = 0; c < 8; c++) begin
      full = (c >= 1 && c <= 3);
      if (c == 7) req = 3'b000;
      sample();
      if (obs_v[0][5]) nwr++;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_v[k] !== exp_v[k]) begin
          errors++;
          $display("FAIL backpressure cyc=%0d dut%0d got %b want %b", c, k, obs_v[k], exp_v[k]);
        end
      end
    end
    full = 1'b0;
    checks++;
    if (nwr !== 4) begin
      errors++;
      $display("FAIL backpressure_writes got %0d want 4", nwr);
    end
  endtask

  task automatic test_class_filter();
    int bad;
    bad = 0;
    apply_reset();
    req = 3'b101; hd1 = 3'b000; hd3 = 3'b001;
    for (int c = 0; c < 8; c++) begin
      sample();
      if (obs_v[1][0] !== 1'b1 || obs_v[1][4:3] === SEL_P1) bad++;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_v[k] !== exp_v[k]) begin
          errors++;
          $display("FAIL class_filter cyc=%0d dut%0d got %b want %b", c, k, obs_v[k], exp_v[k]);
        end
      end
    end
    req = 3'b000;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL class_filter_port1 got %0d grants to port1 want 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    int nwr;
    nwr = 0;
    apply_reset();
    req = 3'b001; hd1 = 3'b000; hd3 = 3'b000;
    sample();
    sample();
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({wr_r, sel_r, busy_r} !== 6'b0_00_111) begin
      errors++;
      $display("FAIL reset_mid_async got %b want 000111", {wr_r, sel_r, busy_r});
    end
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1; req = 3'b100;
    for (int c = 0; c < 4; c++) begin
      sample();
      if (obs_v[0][5] && obs_v[0][4:3] === SEL_P3) nwr++;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_v[k] !== exp_v[k]) begin
          errors++;
          $display("FAIL reset_mid cyc=%0d dut%0d got %b want %b", c, k, obs_v[k], exp_v[k]);
        end
      end
    end
    req = 3'b000;
    checks++;
    if (nwr !== 4) begin
      errors++;
      $display("FAIL reset_mid_writes got %0d want 4", nwr);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    req = 3'b101; hd1 = 3'b000; hd3 = 3'b000;
    for (int c = 0; c < 22; c++) begin
      if (c == 1) req = 3'b100;
      sample();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_v[k] !== exp_v[k]) begin
          errors++;
          $display("FAIL timeout cyc=%0d dut%0d got %b want %b", c, k, obs_v[k], exp_v[k]);
        end
      end
    end
    req = 3'b000;
  endtask

  task automatic test_random();
    logic [2:0] pick[3];
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) pick[i] = 3'($urandom_range(0, 2));
      hd1 = pick[0]; hd2 = pick[1]; hd3 = pick[2];
      req  = 3'($urandom_range(0, 7));
      full = ($urandom_range(0, 3) == 0);
      sample();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_v[k] !== exp_v[k]) begin
          errors++;
          $display("FAIL random cyc=%0d dut%0d got %b want %b", c, k, obs_v[k], exp_v[k]);
        end
      end
    end
    req = 3'b000; full = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_packet();
    test_fairness();
    test_backpressure();
    test_class_filter();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
